// File: rtl/sd_cmd_sequencer_if.sv
// Control/register-side bundle of the sigma-delta command sequencer.
// Strobe semantics: there is no valid/ready backpressure on this bundle.
// wrEn, start and stop are single-cycle strobes sampled on the rising clk
// edge; the sequencer always accepts them. sdCmd, step, busy, done and
// runState are registered and change only just after that edge.
interface sd_cmd_sequencer_if #(
   parameter int WIDTH       = 4,
   parameter int DWELL_WIDTH = 16,
   parameter int AW          = 3
);
   logic                    wrEn;
   logic [AW-1:0]           wrAddr;
   logic signed [WIDTH-1:0] wrCmd;
   logic [DWELL_WIDTH-1:0]  wrDwell;
   logic [AW-1:0]           lastStep;
   logic                    loop;
   logic                    start;
   logic                    stop;
   logic signed [WIDTH-1:0] sdCmd;
   logic [AW-1:0]           step;
   logic                    busy;
   logic                    done;
   logic                    runState;   // debug view of the FSM: 1 = RUN

   modport master (
      output wrEn, wrAddr, wrCmd, wrDwell, lastStep, loop, start, stop,
      input  sdCmd, step, busy, done, runState
   );

   modport slave (
      input  wrEn, wrAddr, wrCmd, wrDwell, lastStep, loop, start, stop,
      output sdCmd, step, busy, done, runState
   );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// Programmable {command, dwell} table player that drives the signed input
// word of one sdDac. Dwell counting advances only on en-high cycles, so an
// entry with dwell D is presented for D+1 sigma-delta cycles.
module sd_cmd_sequencer #(
   parameter int WIDTH       = 4,
   parameter int DEPTH       = 8,
   parameter int DWELL_WIDTH = 16,
   parameter int AW          = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   sd_cmd_sequencer_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic signed [WIDTH-1:0] PARK  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [DWELL_WIDTH-1:0]  ONE_D = 1;
   localparam logic [AW-1:0]           ONE_S = 1;

   logic signed [WIDTH-1:0] cmdMem   [DEPTH];
   logic [DWELL_WIDTH-1:0]  dwellMem [DEPTH];

   state_t                  state, stateNxt;
   logic [DWELL_WIDTH-1:0]  dwellCnt, dwellCntNxt;
   logic [AW-1:0]           stepR, stepNxt, lastL, lastNxt;
   logic                    loopL, loopNxt;
   logic signed [WIDTH-1:0] cmdR, cmdNxt;
   logic                    doneR, doneNxt;
   logic [AW-1:0]           stepInc;
   logic                    startOk;
   logic                    entryEnd;
   logic                    lastEntry;

   assign stepInc   = stepR + ONE_S;
   assign startOk   = bus.start && !bus.stop;
   assign entryEnd  = en && (dwellCnt == '0);
   assign lastEntry = (stepR == lastL);

   // Table storage: written in any state and never cleared by rst; a reload
   // on the same edge as a write sees the pre-write contents.
   always_ff @(posedge clk) begin
      if (bus.wrEn) begin
         cmdMem[bus.wrAddr]   <= bus.wrCmd;
         dwellMem[bus.wrAddr] <= bus.wrDwell;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNxt;
   end

   // Next state: stop always wins; natural completion only without loop.
   always_comb begin
      stateNxt = state;
      case (state)
         IDLE: if (startOk) stateNxt = RUN;
         RUN: begin
            if (bus.stop)                          stateNxt = IDLE;
            else if (entryEnd && lastEntry && !loopL) stateNxt = IDLE;
         end
         default: stateNxt = IDLE;
      endcase
   end

   // Datapath next values: entry load on start, dwell countdown, step
   // advance/wrap, park on abort, one-cycle done on natural completion.
   always_comb begin
      dwellCntNxt = dwellCnt;
      stepNxt     = stepR;
      cmdNxt      = cmdR;
      lastNxt     = lastL;
      loopNxt     = loopL;
      doneNxt     = 1'b0;
      case (state)
         IDLE: begin
            if (startOk) begin
               stepNxt     = '0;
               cmdNxt      = cmdMem[0];
               dwellCntNxt = dwellMem[0];
               lastNxt     = bus.lastStep;
               loopNxt     = bus.loop;
            end
         end
         RUN: begin
            if (bus.stop) begin
               cmdNxt = PARK;
            end else if (en) begin
               if (dwellCnt != '0) begin
                  dwellCntNxt = dwellCnt - ONE_D;
               end else if (!lastEntry) begin
                  stepNxt     = stepInc;
                  cmdNxt      = cmdMem[stepInc];
                  dwellCntNxt = dwellMem[stepInc];
               end else if (loopL) begin
                  stepNxt     = '0;
                  cmdNxt      = cmdMem[0];
                  dwellCntNxt = dwellMem[0];
               end else begin
                  doneNxt = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         dwellCnt <= '0;
         stepR    <= '0;
         cmdR     <= PARK;
         lastL    <= '0;
         loopL    <= 1'b0;
         doneR    <= 1'b0;
      end else begin
         dwellCnt <= dwellCntNxt;
         stepR    <= stepNxt;
         cmdR     <= cmdNxt;
         lastL    <= lastNxt;
         loopL    <= loopNxt;
         doneR    <= doneNxt;
      end
   end

   assign bus.sdCmd    = cmdR;
   assign bus.step     = stepR;
   assign bus.busy     = (state == RUN);
   assign bus.done     = doneR;
   assign bus.runState = (state == RUN);
endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
Programmable command sequencer for a signed sigma-delta DAC (sdDac) input. It holds a small table of {command, dwell} entries and steps through them, driving the DAC's signed input word. Replaces hand-written stimulus/ramp logic in front of sdDac/sdAverage chains. It sits between a control/register interface and one sdDac instance, sharing that instance's clk, rst and en.

Parameters:
WIDTH, 4, width of the signed DAC command word
DEPTH, 8, number of table entries (power of 2, >=2)
DWELL_WIDTH, 16, width of the per-entry dwell count
AW, 3, table address width, must equal log2(DEPTH)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous and active high
en  in  1  sigma-delta enable; dwell counting only advances while high
wrEn  in  1  table write strobe
wrAddr  in  AW  table write address
wrCmd  in  WIDTH  signed command to store
wrDwell  in  DWELL_WIDTH  dwell to store
lastStep  in  AW  index of the final entry; sampled on start
loop  in  1  1 = wrap to entry 0 after lastStep; sampled on start
start  in  1  single-cycle start request
stop  in  1  single-cycle abort request
sdCmd  out  WIDTH  signed command to the sdDac input, registered
step  out  AW  index of the active entry, registered
busy  out  1  high while a sequence is running
done  out  1  one-cycle pulse on natural completion

Behaviour:
- Reset values: sdCmd = -2^(WIDTH-1) (PARK value, -8 at default), step = 0, busy = 0, done = 0, state = IDLE, dwellCnt = 0.
- Table contents are not cleared by rst.
- Table: DEPTH x {WIDTH + DWELL_WIDTH} registers. A write occurs on the clk edge when wrEn=1, in any state.
- A write to the active entry does not alter the current sdCmd or dwellCnt. It takes effect on the entry's next visit.
- Two states: IDLE and RUN.
- IDLE:
  - busy = 0; sdCmd holds its last value (PARK after reset or stop).
  - start=1 and stop=0: at the next edge, go to RUN. step <= 0, sdCmd <= cmd[0], dwellCnt <= dwell[0], busy <= 1, lastStep and loop are latched.
  - sdCmd is therefore valid 1 cycle after start.
  - start and stop together: stop wins; remain in IDLE.
- RUN:
  - start is ignored. lastStep/loop input changes are ignored (latched copies are used).
  - en=0: dwellCnt, step and sdCmd freeze.
  - en=1 and dwellCnt != 0: dwellCnt decrements by 1.
  - en=1 and dwellCnt == 0 (end of entry):
    - step != lastStep_l: step <= step+1, and sdCmd and dwellCnt are reloaded from that entry.
    - step == lastStep_l and loop_l=1: step <= 0, and sdCmd and dwellCnt are reloaded from entry 0.
    - step == lastStep_l and loop_l=0: go to IDLE, busy <= 0, done = 1 for exactly one cycle. sdCmd holds the last entry's command (not parked).
  - Each entry with dwell D is presented for exactly D+1 en-high cycles. D=0 is legal (1 cycle).
  - stop=1: at the next edge, go to IDLE, sdCmd <= PARK, busy <= 0, done stays 0. stop has priority over any step advance in the same cycle.
- Wrap-around: step width is AW, so lastStep = DEPTH-1 is always legal. No out-of-range index exists.
- Simultaneous write and reload of the same entry: the reload uses the old (pre-write) table value.
- rst mid-sequence: all outputs return to reset values on the next edge. The table is kept, so a following start replays the same program.
- done and busy never both high. done is asserted in the cycle busy first reads 0.

Test Plan:
1. Reset, program 4 entries (-8,d2),(0,d2),(7,d2),(-8,d2), lastStep=3, loop=0, en=1, pulse start -> sdCmd follows -8,-8,-8,0,0,0,7,7,7,-8,-8,-8 starting 1 cycle after start; then done pulses once, busy falls, sdCmd stays -8.
2. Same program with loop=1 -> after entry 3 the output returns to -8 of entry 0 with no gap cycle; busy stays 1 for 3 full loops; stop pulse -> next cycle sdCmd=-8, busy=0, done=0.
3. en toggled 1,0,0,1 during entry 1 (dwell 2) -> entry 1 lasts 3 en-high cycles (5 clocks total); step and sdCmd frozen while en=0.
4. Dwell 0 on all entries, lastStep=7 -> sdCmd changes every cycle across 8 entries; done exactly 8 cycles after the first valid sdCmd.
5. Running entry 2, write entry 2 cmd=3 -> current 7 unchanged; on loop revisit entry 2 presents 3. Write entry 0 in the cycle entry 0 is reloaded -> old value is used.
6. start+stop same cycle in IDLE -> remains IDLE; rst asserted mid-RUN -> sdCmd=-8, step=0, busy=0; a subsequent start replays the unchanged table.
